uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, tx_clk frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, line baud rate.
REQ-003 Derived constants: BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer division; 434 at defaults); BAUD_HALF = BAUD_CNT_MAX/2 (217 at defaults).
REQ-004 tx_clk  input  1  clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 uart_rxd  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-007 uart_rx_data  output  8  last correctly framed byte; held until the next good frame.
REQ-008 uart_rx_done  output  1  one-cycle pulse: uart_rx_data updated this cycle.
REQ-009 uart_rx_busy  output  1  high while a frame is being received.
REQ-010 uart_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-011 uart_rxd SHALL pass through a 2-flop synchronizer; all decisions SHALL use the second-stage value (rxd_s).
REQ-012 A start edge SHALL be detected in IDLE when the registered previous rxd_s is 1 and the current rxd_s is 0.
REQ-013 States: IDLE, START, DATA, STOP; encoding is free.
REQ-014 IDLE->START on start edge; baud_cnt cleared to 0 and uart_rx_busy set on the same edge.
REQ-015 Outside IDLE, baud_cnt SHALL count 0..BAUD_CNT_MAX-1 and wrap; the sample point is baud_cnt == BAUD_HALF.
REQ-016 START, at sample point: rxd_s=1 -> IDLE, busy cleared, no pulses (glitch reject); rxd_s=0 -> DATA, bit_cnt=0.
REQ-017 DATA, at each sample point: shift rxd_s into bit position bit_cnt of the shift register, then increment bit_cnt; after bit_cnt 7 -> STOP.
REQ-018 STOP, at sample point: rxd_s=1 -> uart_rx_data <= shift register, uart_rx_done pulse; rxd_s=0 -> uart_frame_err pulse, uart_rx_data unchanged.
REQ-019 On either STOP outcome -> IDLE and busy cleared on the same edge; the next start edge SHALL be accepted the following cycle.
REQ-020 Timing: with T0 = the edge at which the first sync flop captures 0, sample k (0 = start, 1-8 = data, 9 = stop) SHALL occur at T0+2+BAUD_HALF+k*BAUD_CNT_MAX.
REQ-021 At defaults the stop sample is T0+4125; done or frame_err is high for the single cycle after that edge.
REQ-022 uart_rx_done and uart_frame_err SHALL never be high in the same cycle.
REQ-023 Falling edges on rxd_s outside IDLE SHALL be ignored.
REQ-024 A line held low (break) SHALL produce exactly one frame_err and no done, then wait in IDLE for a high-to-low transition.

Reset
REQ-025 During rst_n low: state=IDLE, baud_cnt=0, bit_cnt=0, shift register=0, uart_rx_data=8'h00, uart_rx_done=0, uart_frame_err=0, uart_rx_busy=0.
REQ-026 Both sync flops and the edge register SHALL reset to 1, so a low line at reset release is not taken as a start edge.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no done or frame_err pulse, and uart_rx_data SHALL read 8'h00.

Structure
REQ-028 Package uart_pkg SHALL hold the default CLK_FREQ/UART_BPS, the BAUD_CNT_MAX/BAUD_HALF derivation, and the rx state enum.
REQ-029 One sub-module, uart_sync, SHALL implement the 2-flop synchronizer plus falling-edge detect (outputs rxd_s, fall).
REQ-030 baud_cnt SHALL be 16 bits, bit_cnt 3 bits; counters SHALL wrap by explicit compare, never by overflow.

Verification
REQ-031 Send 8'hA5 at 115200 bps from an ideal driver -> one done pulse at T0+4125, uart_rx_data=8'hA5, frame_err never high.
REQ-032 Send 8'h00 then 8'hFF back-to-back with a 1-bit stop -> two done pulses 4340 cycles apart, data 8'h00 then 8'hFF.
REQ-033 Drive a 100-cycle low glitch on an idle line -> busy high for about 219 cycles, then IDLE; no done, no frame_err, data unchanged.
REQ-034 Send 8'h3C with the stop bit forced low -> one frame_err pulse at T0+4125, no done, uart_rx_data keeps its previous value.
REQ-035 Assert rst_n low at data bit 4 of 8'h5A, release, then send 8'h12 -> no pulses for the aborted frame; done with 8'h12.
REQ-036 Send 8'h55 with the driver 2% fast and again 2% slow -> done and 8'h55 both times.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receive path.
//   - default tx_clk frequency and line baud rate
//   - baud_cnt_max / baud_half: per-bit and mid-bit cycle counts
//   - rx_state_t: receiver state encoding
package uart_pkg;

    localparam int unsigned CLK_FREQ_DEF = 50_000_000;
    localparam int unsigned UART_BPS_DEF = 115_200;

    // Clock cycles per bit (integer division, 434 at the defaults).
    function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned uart_bps);
        return clk_freq / uart_bps;
    endfunction

    // Mid-bit offset used as the sample point (217 at the defaults).
    function automatic int unsigned baud_half(input int unsigned clk_freq,
                                              input int unsigned uart_bps);
        return baud_cnt_max(clk_freq, uart_bps) / 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// uart_sync -- two-flop synchronizer for the asynchronous serial line plus a
// falling-edge detector on the synchronized value.
// Ports:
//   tx_clk    in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   uart_rxd  in   raw serial line (asynchronous, idle high)
//   rxd_s     out  second-stage synchronized line
//   fall      out  rxd_s was 1 last cycle and is 0 now
module uart_sync (
    input  logic tx_clk,
    input  logic rst_n,
    input  logic uart_rxd,
    output logic rxd_s,
    output logic fall
);

    logic sync_1;
    logic rxd_prev;

    // All three flops reset to the idle-line level.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1   <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            sync_1   <= uart_rxd;
            rxd_s    <= sync_1;
            rxd_prev <= rxd_s;
        end
    end

    assign fall = rxd_prev & ~rxd_s;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1, LSB-first UART receiver clocked by tx_clk.
// Each bit is sampled once at mid-bit; a start bit that is high again at its
// mid-bit is treated as a glitch and dropped silently.
// Ports:
//   tx_clk          in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   uart_rxd        in   serial line, idle high
//   uart_rx_data    out  last correctly framed byte, held until the next one
//   uart_rx_done    out  one-cycle pulse, uart_rx_data updated this cycle
//   uart_rx_busy    out  high while a frame is being received
//   uart_frame_err  out  one-cycle pulse, stop bit sampled low
//   rx_state        out  current receiver state (observation only)
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
    parameter int unsigned UART_BPS = UART_BPS_DEF
) (
    input  logic       tx_clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_done,
    output logic       uart_rx_busy,
    output logic       uart_frame_err,
    output rx_state_t  rx_state
);

    localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int unsigned BAUD_HALF    = baud_half(CLK_FREQ, UART_BPS);

    localparam logic [15:0] CNT_LAST   = 16'(BAUD_CNT_MAX - 1);
    // baud_cnt is cleared on the start edge, so the edge that loads
    // BAUD_HALF into it is the one where the count currently reads
    // BAUD_HALF-1. Acting on that edge puts sample k exactly
    // BAUD_HALF + k*BAUD_CNT_MAX cycles after the start edge.
    localparam logic [15:0] CNT_SAMPLE = 16'(BAUD_HALF - 1);

    logic        rxd_s;
    logic        fall;
    rx_state_t   state;
    rx_state_t   state_next;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        sample;

    uart_sync u_sync (
        .tx_clk   (tx_clk),
        .rst_n    (rst_n),
        .uart_rxd (uart_rxd),
        .rxd_s    (rxd_s),
        .fall     (fall)
    );

    assign sample   = (baud_cnt == CNT_SAMPLE);
    assign rx_state = state;

    // State register.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Falls on rxd_s only matter in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_next = START;
                end
            end
            START: begin
                if (sample) begin
                    state_next = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample && (bit_cnt == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, shift register and registered outputs.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt       <= 16'd0;
            bit_cnt        <= 3'd0;
            shift_reg      <= 8'h00;
            uart_rx_data   <= 8'h00;
            uart_rx_done   <= 1'b0;
            uart_frame_err <= 1'b0;
            uart_rx_busy   <= 1'b0;
        end else begin
            uart_rx_done   <= 1'b0;
            uart_frame_err <= 1'b0;
            uart_rx_busy   <= (state_next != IDLE);

            // Held at zero in IDLE, so it starts from 0 on the start edge.
            if (state == IDLE) begin
                baud_cnt <= 16'd0;
            end else if (baud_cnt == CNT_LAST) begin
                baud_cnt <= 16'd0;
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end

            if (sample) begin
                case (state)
                    START: begin
                        if (!rxd_s) begin
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_reg[bit_cnt] <= rxd_s;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    STOP: begin
                        if (rxd_s) begin
                            uart_rx_data <= shift_reg;
                            uart_rx_done <= 1'b1;
                        end else begin
                            uart_frame_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_pkg::*;

  localparam int MAX  = int'(baud_cnt_max(CLK_FREQ_DEF, UART_BPS_DEF));
  localparam int HALF = int'(baud_half(CLK_FREQ_DEF, UART_BPS_DEF));
  localparam int EW   = 41;   // {is_err, data[7:0], time[31:0]}
  localparam int WAVE_LEN = 8192;

  // ---------------- clock / reset ----------------
  logic       tx_clk;
  logic       rst_n;
  logic       uart_rxd;
  logic [7:0] uart_rx_data;
  logic       uart_rx_done;
  logic       uart_rx_busy;
  logic       uart_frame_err;
  rx_state_t  rx_state;

  int cyc = 0;

  initial begin
    tx_clk = 1'b0;
    forever #10 tx_clk = ~tx_clk;
  end

  always @(posedge tx_clk) cyc <= cyc + 1;

  uart_rx dut (
    .tx_clk         (tx_clk),
    .rst_n          (rst_n),
    .uart_rxd       (uart_rxd),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_done   (uart_rx_done),
    .uart_rx_busy   (uart_rx_busy),
    .uart_frame_err (uart_frame_err),
    .rx_state       (rx_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [7:0]    last_good = 8'h00;
  logic          wave[WAVE_LEN];
  int            checks = 0;
  int            errors = 0;

  task automatic check_val(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Line level seen by the receiver t cycles after the first sync flop
  // captured the start bit; beyond the waveform the line is idle high.
  function automatic logic lvl(input int t, input int n);
    if (t < n) return wave[t];
    return 1'b1;
  endfunction

  // Bit k of a frame is taken from the line level HALF + k*MAX cycles into
  // the frame; the outcome is registered 2 cycles later (synchronizer).
  task automatic model_push(input int n);
    logic [7:0] d;
    logic       stp;
    int         t_exp;
    if (wave[0] != 1'b0) return;
    if (lvl(HALF, n) != 1'b0) return;
    for (int k = 1; k <= 8; k++) d[k-1] = lvl(HALF + k * MAX, n);
    stp   = lvl(HALF + 9 * MAX, n);
    t_exp = cyc + 1 + 2 + HALF + 9 * MAX;
    if (stp) begin
      exp_q.push_back({1'b0, d, 32'(t_exp)});
      last_good = d;
    end else begin
      exp_q.push_back({1'b1, last_good, 32'(t_exp)});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic build_frame(input logic [7:0] b, input int len, input logic stop_lvl,
                             output int n);
    for (int i = 0; i < 10; i++) begin
      logic lv;
      if (i == 0) lv = 1'b0;
      else if (i == 9) lv = stop_lvl;
      else lv = b[i-1];
      for (int j = 0; j < len; j++) wave[i*len + j] = lv;
    end
    n = 10 * len;
  endtask

  // Called right after a falling clock edge.
  task automatic play_wave(input int n, output int busy_cnt);
    model_push(n);
    busy_cnt = 0;
    for (int t = 0; t < n; t++) begin
      uart_rxd = wave[t];
      @(negedge tx_clk);
      busy_cnt += int'(uart_rx_busy);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input int len, input logic stop_lvl);
    int n;
    int bc;
    build_frame(b, len, stop_lvl, n);
    play_wave(n, bc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge tx_clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge tx_clk) begin
    if (rst_n) begin
      if (uart_rx_done && uart_frame_err)
        check_val("done_and_err_together", 1, 0);
      if (uart_rx_done || uart_frame_err) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_pulse", {uart_frame_err, uart_rx_done}, 0);
        end else begin
          logic [EW-1:0] e;
          logic          e_err;
          logic [7:0]    e_data;
          logic [31:0]   e_t;
          e = exp_q.pop_front();
          {e_err, e_data, e_t} = e;
          check_val("pulse_is_err", uart_frame_err, e_err);
          check_val("pulse_cycle", cyc, e_t);
          check_val(e_err ? "held_data" : "rx_data", uart_rx_data, e_data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int bc;
    int cut;
    int guard;

    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    idle(5);
    check_val("reset_data", uart_rx_data, 8'h00);
    check_val("reset_done", uart_rx_done, 0);
    check_val("reset_err", uart_frame_err, 0);
    check_val("reset_busy", uart_rx_busy, 0);
    check_val("reset_state", rx_state, IDLE);
    rst_n = 1'b1;
    idle(20);

    // single frame
    send(8'hA5, MAX, 1'b1);
    idle(20);

    // back-to-back frames, one-bit stop
    send(8'h00, MAX, 1'b1);
    send(8'hFF, MAX, 1'b1);
    idle(20);

    // 100-cycle glitch on an idle line
    for (int t = 0; t < 500; t++) wave[t] = (t < 100) ? 1'b0 : 1'b1;
    play_wave(500, bc);
    check_val("glitch_busy_cycles", bc, HALF);
    check_val("glitch_data_kept", uart_rx_data, last_good);
    check_val("glitch_state", rx_state, IDLE);
    idle(20);

    // stop bit forced low
    send(8'h3C, MAX, 1'b0);
    idle(20);

    // break: line held low well past a frame
    for (int t = 0; t < 6000; t++) wave[t] = 1'b0;
    play_wave(6000, bc);
    idle(20);

    // reset in the middle of data bit 4
    build_frame(8'h5A, MAX, 1'b1, n);
    cut = 5 * MAX + MAX / 2;
    for (int t = 0; t < cut; t++) begin
      uart_rxd = wave[t];
      @(negedge tx_clk);
    end
    check_val("abort_busy_before_reset", uart_rx_busy, 1);
    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    idle(10);
    check_val("abort_data", uart_rx_data, 8'h00);
    check_val("abort_busy", uart_rx_busy, 0);
    last_good = 8'h00;
    rst_n = 1'b1;
    idle(20);
    send(8'h12, MAX, 1'b1);
    idle(20);

    // baud mismatch, 2% fast then 2% slow
    send(8'h55, MAX - MAX / 50, 1'b1);
    idle(20);
    send(8'h55, MAX + MAX / 50, 1'b1);
    idle(20);

    // randomized frames
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b;
      int         len;
      logic       stp;
      b   = 8'($urandom_range(0, 255));
      len = MAX - 8 + int'($urandom_range(0, 16));
      stp = ($urandom_range(0, 3) != 0);
      send(b, len, stp);
      idle(int'($urandom_range(2, 50)));
    end

    // drain
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(negedge tx_clk);
      guard++;
    end
    check_val("outstanding_expected", exp_q.size(), 0);
    check_val("final_data", uart_rx_data, last_good);
    check_val("final_busy", uart_rx_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
